// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration-chain loader and its CRC helper.
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StCheck,
        StDone
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/cfg_crc16.sv
// Serial CRC-16-CCITT, one message bit per enabled cycle, MSB-first, no reflection.
module cfg_crc16
    import cfg_loader_pkg::*;
(
    input  logic        clk,
    input  logic        nrst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;
    logic        fb;

    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[15] ^ din;
        if (clr) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/cfg_chain_loader.sv
// Streams bitstream words MSB-first into the fabric config chain for exactly CHAIN_LEN enables.
// Optional CRC-16 trailer check is built when CFG_CHAIN_CRC_EN is defined.
module cfg_chain_loader
    import cfg_loader_pkg::*;
#(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned CHAIN_LEN = 272
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              cfg_en,
    output logic              cfg_data,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WB_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  LAST_WB  = WB_W'(WORD_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WB_W-1:0]   word_bit_q, word_bit_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              last_bit, word_end;

`ifdef CFG_CHAIN_CRC_EN
    logic        crc_err_q, crc_err_d;
    logic        crc_clr;
    logic [15:0] crc;
`endif

    assign last_bit = (bit_cnt_q == LAST_BIT);
    assign word_end = (word_bit_q == LAST_WB);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_bit_d = word_bit_q;
        shreg_d    = shreg_q;
        s_ready    = 1'b0;
`ifdef CFG_CHAIN_CRC_EN
        crc_err_d  = crc_err_q;
        crc_clr    = 1'b0;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StLoad;
                    bit_cnt_d = '0;
`ifdef CFG_CHAIN_CRC_EN
                    crc_err_d = 1'b0;
                    crc_clr   = 1'b1;
`endif
                end
            end
            StLoad: begin
                // Gate ready with abort so the source never sees an accept that is discarded.
                s_ready = !abort;
                if (abort) begin
                    state_d = StIdle;
                end else if (s_valid) begin
                    shreg_d    = s_data;
                    word_bit_d = '0;
                    state_d    = StShift;
                end
            end
            StShift: begin
                shreg_d    = shreg_q << 1;
                word_bit_d = word_bit_q + 1'b1;
                bit_cnt_d  = bit_cnt_q + 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (last_bit) begin
`ifdef CFG_CHAIN_CRC_EN
                    state_d = StCheck;
`else
                    state_d = StDone;
`endif
                end else if (word_end) begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        shreg_d    = s_data;
                        word_bit_d = '0;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
`ifdef CFG_CHAIN_CRC_EN
            StCheck: begin
                s_ready = !abort;
                if (abort) begin
                    state_d = StIdle;
                end else if (s_valid) begin
                    crc_err_d = (16'(s_data) != crc);
                    state_d   = StDone;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            word_bit_q <= '0;
            shreg_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_bit_q <= word_bit_d;
            shreg_q    <= shreg_d;
        end
    end

    assign cfg_en   = (state_q == StShift);
    assign cfg_data = cfg_en & shreg_q[WORD_W-1];
    assign busy     = (state_q == StLoad) || (state_q == StShift) || (state_q == StCheck);
    assign done     = (state_q == StDone);

`ifdef CFG_CHAIN_CRC_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            crc_err_q <= 1'b0;
        end else begin
            crc_err_q <= crc_err_d;
        end
    end

    cfg_crc16 u_crc (
        .clk  (clk),
        .nrst (nrst),
        .clr  (crc_clr),
        .en   (cfg_en),
        .din  (cfg_data),
        .crc  (crc)
    );

    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

endmodule
